display_scan_ctrl: RTL and testbench

//  Time-multiplexing controller for the 4-digit display path. Sits directly

---
 rtl/display_scan_ctrl_if.sv | 28 ++
 rtl/display_scan_ctrl.sv | 121 ++++++++++++
 tb/tb_display_scan_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/display_scan_ctrl_if.sv
// Scan controller bundle: run/mask in,
// digit mux select/strobe and anodes out.
interface display_scan_ctrl_if;
  logic       run;
  logic [3:0] digit_mask;
  logic [1:0] sel;
  logic       en;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output run,
    output digit_mask,
    input  sel,
    input  en,
    input  an,
    input  frame_done
  );

  modport slave (
    input  run,
    input  digit_mask,
    output sel,
    output en,
    output an,
    output frame_done
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// 4-digit display scan: blank gap between
// digits, masked digits skipped, frame pulse.
module display_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  display_scan_ctrl_if.slave scan
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  localparam logic [CNT_W-1:0] DIV_END =
    CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLK_END =
    CNT_W'(BLANK - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       sel_q;
  logic             en_q;
  logic [3:0]       an_q;
  logic             fd_q;

  logic [1:0] first_d;
  logic [1:0] nxt_d;
  logic       any_d;

  // first set mask bit at or after 'from', wrapping mod 4
  function automatic logic [1:0] next_set(
    input logic [1:0] from,
    input logic [3:0] m
  );
    logic [1:0] idx;
    next_set = from;
    for (int i = 3; i >= 0; i--) begin
      idx = from + 2'(i);
      if (m[idx]) next_set = idx;
    end
  endfunction

  assign any_d   = |scan.digit_mask;
  assign first_d = next_set(2'd0, scan.digit_mask);
  assign nxt_d   = next_set(sel_q + 2'd1,
                            scan.digit_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      an_q    <= 4'b1111;
      fd_q    <= 1'b0;
    end else begin
      en_q <= 1'b0;
      fd_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          an_q  <= 4'b1111;
          cnt_q <= '0;
          if (scan.run && any_d) begin
            sel_q   <= first_d;
            en_q    <= 1'b1;
            state_q <= S_BLANK;
          end
        end
        S_BLANK: begin
          an_q <= 4'b1111;
          if (!scan.run) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == BLK_END) begin
            cnt_q   <= '0;
            an_q    <= ~(4'b0001 << sel_q);
            state_q <= S_SHOW;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_SHOW: begin
          if (!scan.run) begin
            cnt_q   <= '0;
            an_q    <= 4'b1111;
            state_q <= S_IDLE;
          end else if (cnt_q == DIV_END) begin
            cnt_q <= '0;
            an_q  <= 4'b1111;
            if (!any_d) begin
              state_q <= S_IDLE;
            end else begin
              sel_q   <= nxt_d;
              en_q    <= 1'b1;
              fd_q    <= (nxt_d <= sel_q);
              state_q <= S_BLANK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          an_q    <= 4'b1111;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign scan.sel        = sel_q;
  assign scan.en         = en_q;
  assign scan.an         = an_q;
  assign scan.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl
// with DIV=8, BLANK=2.
module tb_display_scan_ctrl;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  display_scan_ctrl_if scan ();

  display_scan_ctrl #(
    .DIV  (8),
    .BLANK(2),
    .CNT_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .scan (scan.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h",
               tag, got, exp);
    end
  endtask

  // negedge after the edge that loads digit d,
  // then the second blank cycle
  task automatic exp_load(
    input logic [1:0] d,
    input logic       fd
  );
    @(negedge clk);
    chk("ld_sel", 32'(scan.sel), 32'(d));
    chk("ld_en", 32'(scan.en), 32'd1);
    chk("ld_an", 32'(scan.an), 32'hf);
    chk("ld_fd", 32'(scan.frame_done),
        32'(fd));
    @(negedge clk);
    chk("bl_en", 32'(scan.en), 32'd0);
    chk("bl_an", 32'(scan.an), 32'hf);
    chk("bl_fd", 32'(scan.frame_done), 32'd0);
  endtask

  task automatic exp_show(
    input logic [1:0] d,
    input int         n
  );
    logic [3:0] a;
    a = ~(4'b0001 << d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sh_an", 32'(scan.an), 32'(a));
      chk("sh_sel", 32'(scan.sel), 32'(d));
      chk("sh_en", 32'(scan.en), 32'd0);
      chk("sh_fd", 32'(scan.frame_done),
          32'd0);
    end
  endtask

  task automatic exp_digit(
    input logic [1:0] d,
    input logic       fd
  );
    exp_load(d, fd);
    exp_show(d, 8);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    scan.run = 1'b0;
    scan.digit_mask = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_an", 32'(scan.an), 32'hf);
    chk("rst_sel", 32'(scan.sel), 32'd0);
    chk("rst_en", 32'(scan.en), 32'd0);
    chk("rst_fd", 32'(scan.frame_done), 32'd0);
    rst_n = 1'b1;

    // 1: all four digits, wrap 3->0
    scan.run = 1'b1;
    scan.digit_mask = 4'b1111;
    exp_digit(2'd0, 1'b0);
    exp_digit(2'd1, 1'b0);
    exp_digit(2'd2, 1'b0);
    exp_digit(2'd3, 1'b0);
    exp_digit(2'd0, 1'b1);
    exp_digit(2'd1, 1'b0);
    exp_digit(2'd2, 1'b0);
    exp_digit(2'd3, 1'b0);
    exp_digit(2'd0, 1'b1);

    // 2: digits 0 and 2
    scan.digit_mask = 4'b0101;
    exp_digit(2'd2, 1'b0);
    exp_digit(2'd0, 1'b1);
    exp_digit(2'd2, 1'b0);
    exp_digit(2'd0, 1'b1);

    // 3: single digit 3
    scan.digit_mask = 4'b1000;
    exp_digit(2'd3, 1'b0);
    exp_digit(2'd3, 1'b1);
    exp_digit(2'd3, 1'b1);

    // 4: empty mask parks in idle
    scan.digit_mask = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("idl_an", 32'(scan.an), 32'hf);
      chk("idl_en", 32'(scan.en), 32'd0);
      chk("idl_fd", 32'(scan.frame_done),
          32'd0);
    end
    scan.digit_mask = 4'b0010;
    exp_digit(2'd1, 1'b0);

    // 5: drop run mid-show on digit 2
    scan.digit_mask = 4'b0100;
    exp_load(2'd2, 1'b0);
    exp_show(2'd2, 4);
    scan.run = 1'b0;
    @(negedge clk);
    chk("stp_an", 32'(scan.an), 32'hf);
    chk("stp_sel", 32'(scan.sel), 32'd2);
    chk("stp_en", 32'(scan.en), 32'd0);
    chk("stp_fd", 32'(scan.frame_done), 32'd0);
    @(negedge clk);
    chk("stp_an2", 32'(scan.an), 32'hf);
    chk("stp_sel2", 32'(scan.sel), 32'd2);
    scan.digit_mask = 4'b0101;
    scan.run = 1'b1;
    exp_digit(2'd0, 1'b0);

    // 6: async reset mid-show
    exp_load(2'd2, 1'b0);
    exp_show(2'd2, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_an", 32'(scan.an), 32'hf);
    chk("ar_sel", 32'(scan.sel), 32'd0);
    chk("ar_en", 32'(scan.en), 32'd0);
    chk("ar_fd", 32'(scan.frame_done), 32'd0);
    @(negedge clk);
    chk("ar_an2", 32'(scan.an), 32'hf);
    rst_n = 1'b1;
    exp_digit(2'd0, 1'b0);
    exp_load(2'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d",
             n_chk, n_err);
    $finish;
  end

endmodule
